cd_bcd7seg: RTL and testbench

CD_BCD7SEG -- requirements
Module: cd_bcd7seg

---
 rtl/cd_bcd7seg_pkg.sv | 38 +++
 rtl/cd_bcd7seg_dec.sv | 77 +++++++
 rtl/cd_bcd7seg.sv | 67 ++++++
 tb/tb_cd_bcd7seg.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/cd_bcd7seg_pkg.sv
// Shared constants for the BCD-to-7-segment decoder: segment bit positions and glyph patterns.
// Glyphs are stored with bit SEG_A in the LSB, i.e. {g,f,e,d,c,b,a}, active-high.
package cd_bcd7seg_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam int STYLE_EQN = 0;
  localparam int STYLE_TBL = 1;

  typedef logic [6:0] seg_t;

  localparam seg_t GLYPH_0     = 7'b0111111;
  localparam seg_t GLYPH_1     = 7'b0000110;
  localparam seg_t GLYPH_2     = 7'b1011011;
  localparam seg_t GLYPH_3     = 7'b1001111;
  localparam seg_t GLYPH_4     = 7'b1100110;
  localparam seg_t GLYPH_5     = 7'b1101101;
  localparam seg_t GLYPH_6     = 7'b1111101;
  localparam seg_t GLYPH_7     = 7'b0000111;
  localparam seg_t GLYPH_8     = 7'b1111111;
  localparam seg_t GLYPH_9     = 7'b1101111;
  localparam seg_t GLYPH_A     = 7'b1110111;
  localparam seg_t GLYPH_B     = 7'b1111100;
  localparam seg_t GLYPH_C     = 7'b0111001;
  localparam seg_t GLYPH_D     = 7'b1011110;
  localparam seg_t GLYPH_E     = 7'b1111001;
  localparam seg_t GLYPH_F     = 7'b1110001;
  localparam seg_t GLYPH_BLANK = 7'b0000000;

  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/cd_bcd7seg_dec.sv
// Combinational 4-bit code to active-high segment decoder; STYLE selects equations (0) or a table (1).
// Macro CD_BCD7SEG_HEX_EN makes codes 10..15 show hex glyphs instead of blanking.
module cd_bcd7seg_dec
  import cd_bcd7seg_pkg::*;
#(
  parameter int STYLE = STYLE_EQN
) (
  input  logic [3:0] code_i,
  output seg_t       seg_o
);

  generate
    if (STYLE == STYLE_EQN) begin : g_eqn
      logic d3, d2, d1, d0;
      seg_t lo, hi;

      assign {d3, d2, d1, d0} = code_i;

      // Codes 0..7 and 8..15 are minimised separately, then selected by the MSB.
      always_comb begin
        lo[SEG_A] = d1 | (d2 & d0) | (~d2 & ~d0);
        lo[SEG_B] = ~d2 | (~d1 & ~d0) | (d1 & d0);
        lo[SEG_C] = d2 | ~d1 | d0;
        lo[SEG_D] = (~d2 & ~d0) | (~d2 & d1) | (d1 & ~d0) | (d2 & ~d1 & d0);
        lo[SEG_E] = ~d0 & (~d2 | d1);
        lo[SEG_F] = (~d1 & ~d0) | (d2 & ~d1) | (d2 & ~d0);
        lo[SEG_G] = (~d2 & d1) | (d2 & ~d1) | (d1 & ~d0);
`ifdef CD_BCD7SEG_HEX_EN
        hi[SEG_A] = ~d0 | (d1 & d2) | (~d1 & ~d2);
        hi[SEG_B] = (~d2 & ~d1) | (~d2 & ~d0) | (d2 & ~d1 & d0);
        hi[SEG_C] = ~d2 | (~d1 & d0);
        hi[SEG_D] = ~d1 | (~d2 & d0) | (d2 & ~d0);
        hi[SEG_E] = d2 | d1 | ~d0;
        hi[SEG_F] = ~d2 | d1 | ~d0;
        hi[SEG_G] = ~d2 | d1 | d0;
`else
        hi[SEG_A] = ~d2 & ~d1;
        hi[SEG_B] = ~d2 & ~d1;
        hi[SEG_C] = ~d2 & ~d1;
        hi[SEG_D] = ~d2 & ~d1;
        hi[SEG_E] = ~d2 & ~d1 & ~d0;
        hi[SEG_F] = ~d2 & ~d1;
        hi[SEG_G] = ~d2 & ~d1;
`endif
      end

      assign seg_o = d3 ? hi : lo;
    end else begin : g_tbl
      always_comb begin
        // NOTE: a default is assigned before the case so every path drives seg_o and no latch is inferred.
        seg_o = GLYPH_BLANK;
        case (code_i)
          4'd0:  seg_o = GLYPH_0;
          4'd1:  seg_o = GLYPH_1;
          4'd2:  seg_o = GLYPH_2;
          4'd3:  seg_o = GLYPH_3;
          4'd4:  seg_o = GLYPH_4;
          4'd5:  seg_o = GLYPH_5;
          4'd6:  seg_o = GLYPH_6;
          4'd7:  seg_o = GLYPH_7;
          4'd8:  seg_o = GLYPH_8;
          4'd9:  seg_o = GLYPH_9;
`ifdef CD_BCD7SEG_HEX_EN
          4'd10: seg_o = GLYPH_A;
          4'd11: seg_o = GLYPH_B;
          4'd12: seg_o = GLYPH_C;
          4'd13: seg_o = GLYPH_D;
          4'd14: seg_o = GLYPH_E;
          4'd15: seg_o = GLYPH_F;
`endif
          default: seg_o = GLYPH_BLANK;
        endcase
      end
    end
  endgenerate

endmodule

// File: rtl/cd_bcd7seg.sv
// Registered BCD-to-7-segment driver with cross-checked equation and table decoders.
// Macro CD_BCD7SEG_HEX_EN enables hex glyphs for codes 10..15 (otherwise they blank).
module cd_bcd7seg
  import cd_bcd7seg_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       D,
  input  logic       C,
  input  logic       B,
  input  logic       A,
  output logic       ya,
  output logic       yb,
  output logic       yc,
  output logic       yd,
  output logic       ye,
  output logic       yf,
  output logic       yg,
  output logic [6:0] eq,
  output logic       invalid
);

  localparam seg_t SEG_OFF = {7{SEG_ACTIVE_LOW}};

  logic [3:0] code;
  seg_t       seg_eqn, seg_tbl;
  seg_t       seg_d, seg_q;
  logic [6:0] eq_d, eq_q;
  logic       invalid_d, invalid_q;

  assign code = {D, C, B, A};

  cd_bcd7seg_dec #(.STYLE(STYLE_EQN)) u_dec_eqn (.code_i(code), .seg_o(seg_eqn));
  cd_bcd7seg_dec #(.STYLE(STYLE_TBL)) u_dec_tbl (.code_i(code), .seg_o(seg_tbl));

  assign seg_d     = SEG_ACTIVE_LOW ? ~seg_tbl : seg_tbl;
  assign eq_d      = ~(seg_eqn ^ seg_tbl);
  assign invalid_d = (code > BCD_MAX);

  // Reset outranks enable, so a capture coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (!rst_n) begin
      seg_q     <= SEG_OFF;
      eq_q      <= '1;
      invalid_q <= 1'b0;
    end else if (en) begin
      seg_q     <= seg_d;
      eq_q      <= eq_d;
      invalid_q <= invalid_d;
    end
  end

  assign ya      = seg_q[SEG_A];
  assign yb      = seg_q[SEG_B];
  assign yc      = seg_q[SEG_C];
  assign yd      = seg_q[SEG_D];
  assign ye      = seg_q[SEG_E];
  assign yf      = seg_q[SEG_F];
  assign yg      = seg_q[SEG_G];
  assign eq      = eq_q;
  assign invalid = invalid_q;

endmodule

// File: tb/tb_cd_bcd7seg.sv
// Scoreboard bench for cd_bcd7seg: both polarities driven in parallel, checked against a glyph-table model.
// Expectations for codes 10..15 follow CD_BCD7SEG_HEX_EN when it is defined for the bench build.
module tb_cd_bcd7seg;

  logic clk = 1'b0;
  logic rst_n, en, D, C, B, A;

  logic       ya, yb, yc, yd, ye, yf, yg;
  logic [6:0] eq;
  logic       invalid;
  logic       ya_l, yb_l, yc_l, yd_l, ye_l, yf_l, yg_l;
  logic [6:0] eq_l;
  logic       invalid_l;

  always #5 clk = ~clk;

  cd_bcd7seg #(.SEG_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .D(D), .C(C), .B(B), .A(A),
    .ya(ya), .yb(yb), .yc(yc), .yd(yd), .ye(ye), .yf(yf), .yg(yg),
    .eq(eq), .invalid(invalid)
  );

  cd_bcd7seg #(.SEG_ACTIVE_LOW(1'b1)) dut_l (
    .clk(clk), .rst_n(rst_n), .en(en), .D(D), .C(C), .B(B), .A(A),
    .ya(ya_l), .yb(yb_l), .yc(yc_l), .yd(yd_l), .ye(ye_l), .yf(yf_l), .yg(yg_l),
    .eq(eq_l), .invalid(invalid_l)
  );

  // Expected outputs, with segments written a..g from MSB to LSB, active-high.
  typedef struct packed {
    logic [6:0] seg;
    logic [6:0] eqv;
    logic       inv;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [6:0] m_seg;
  logic [6:0] m_eq;
  logic       m_inv;

  function automatic logic [6:0] glyph(input int code);
    case (code)
      0:  return 7'b1111110;
      1:  return 7'b0110000;
      2:  return 7'b1101101;
      3:  return 7'b1111001;
      4:  return 7'b0110011;
      5:  return 7'b1011011;
      6:  return 7'b1011111;
      7:  return 7'b1110000;
      8:  return 7'b1111111;
      9:  return 7'b1111011;
`ifdef CD_BCD7SEG_HEX_EN
      10: return 7'b1110111;
      11: return 7'b0011111;
      12: return 7'b1001110;
      13: return 7'b0111101;
      14: return 7'b1001111;
      15: return 7'b1000111;
`endif
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus; the model advances once per edge and queues what the DUT must show.
  task automatic step(input bit r, input bit e, input int code);
    logic [3:0] c4;
    c4 = code[3:0];
    rst_n = r;
    en    = e;
    {D, C, B, A} = c4;
    @(posedge clk);
    #1;
    if (!r) begin
      m_seg = 7'b0000000;
      m_eq  = 7'b1111111;
      m_inv = 1'b0;
    end else if (e) begin
      m_seg = glyph(code);
      m_eq  = 7'b1111111;
      m_inv = (code > 9);
    end
    exp_q.push_back('{seg: m_seg, eqv: m_eq, inv: m_inv});
  endtask

  // Monitor: registered outputs are valid every cycle, so one entry is consumed per falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("seg_hi", {25'd0, ya, yb, yc, yd, ye, yf, yg}, {25'd0, e.seg});
        check("eq_hi", {25'd0, eq}, {25'd0, e.eqv});
        check("inv_hi", {31'd0, invalid}, {31'd0, e.inv});
        check("seg_lo", {25'd0, ya_l, yb_l, yc_l, yd_l, ye_l, yf_l, yg_l}, {25'd0, ~e.seg});
        check("eq_lo", {25'd0, eq_l}, {25'd0, e.eqv});
        check("inv_lo", {31'd0, invalid_l}, {31'd0, e.inv});
      end
    end
  end

  initial begin
    m_seg = '0;
    m_eq  = '1;
    m_inv = 1'b0;

    // Reset held for two clocks with arbitrary inputs.
    step(0, 1, int'($urandom_range(0, 15)));
    step(0, 1, int'($urandom_range(0, 15)));

    // Back-to-back sweep over every code.
    for (int i = 0; i < 16; i++) step(1, 1, i);

    // Hold: capture 8, then present 1 with enable low, then release.
    step(1, 1, 8);
    for (int i = 0; i < 3; i++) step(1, 0, 1);
    step(1, 1, 1);

    // Reset on the same edge as a capture of 5, then resume.
    step(1, 1, 0);
    step(0, 1, 5);
    step(1, 0, 5);
    step(1, 1, 3);

    // Randomised traffic with occasional reset and enable gaps.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 15)));
    end

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    check("drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
